// File: rtl/fnn_pkg.sv
// rtl/fnn_pkg.sv - shared fixed-point defaults and saturation helper for the neural datapath
package fnn_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int FRAC_WIDTH = 12;

    // Clamp a wide signed value into the range of a signed word of the given width.
    function automatic logic signed [63:0] saturate(input logic signed [63:0] value, input int width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (value > hi) begin
            return hi;
        end else if (value < lo) begin
            return lo;
        end
        return value;
    endfunction

endpackage

// File: rtl/neuron_mac.sv
// rtl/neuron_mac.sv - streaming multiply-accumulate neuron with bias, rescale, saturation and ReLU
module neuron_mac
    import fnn_pkg::*;
#(
    parameter int numWeight    = 10,
    parameter int addressWidth = $clog2(numWeight),
    parameter int dataWidth    = DATA_WIDTH,
    parameter int fracWidth    = FRAC_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    input  logic signed [dataWidth-1:0]    in_data,
    input  logic signed [dataWidth-1:0]    bias,
    output logic                           ren,
    output logic        [addressWidth-1:0] radd,
    input  logic signed [dataWidth-1:0]    wout,
    output logic signed [dataWidth-1:0]    out_data,
    output logic                           out_valid
);

    localparam int ACC_W = 2 * dataWidth + $clog2(numWeight);
    localparam logic [addressWidth-1:0] LAST = addressWidth'(numWeight - 1);

    logic        [addressWidth-1:0] idx;
    logic        [addressWidth-1:0] cnt;
    logic signed [dataWidth-1:0]    in_d;
    logic                           vld_d;
    logic signed [ACC_W-1:0]        acc;
    logic                           done;

    logic signed [2*dataWidth-1:0]  prod;
    logic signed [ACC_W-1:0]        prod_ext;
    logic signed [ACC_W-1:0]        bias_ext;
    logic signed [ACC_W-1:0]        biased;
    logic signed [ACC_W-1:0]        scaled;
    logic signed [63:0]             sat;
    logic signed [dataWidth-1:0]    relu;

    assign ren  = in_valid;
    assign radd = idx;

    assign prod     = in_d * wout;
    assign prod_ext = {{(ACC_W - 2 * dataWidth){prod[2*dataWidth-1]}}, prod};
    assign bias_ext = {{(ACC_W - dataWidth){bias[dataWidth-1]}}, bias};
    assign biased   = acc + (bias_ext <<< fracWidth);
    assign scaled   = biased >>> fracWidth;
    assign sat      = saturate(64'(scaled), dataWidth);
    assign relu     = (sat < 0) ? '0 : dataWidth'(sat);

    // done marks that acc holds a complete frame; the result is taken on the
    // following edge, which is also free to start the next frame's accumulation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= '0;
            cnt       <= '0;
            in_d      <= '0;
            vld_d     <= 1'b0;
            acc       <= '0;
            done      <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            if (in_valid) begin
                idx <= (idx == LAST) ? '0 : idx + addressWidth'(1);
            end
            in_d      <= in_data;
            vld_d     <= in_valid;
            done      <= 1'b0;
            out_valid <= done;
            if (done) begin
                out_data <= relu;
            end
            if (vld_d) begin
                acc <= (cnt == '0) ? prod_ext : acc + prod_ext;
                if (cnt == LAST) begin
                    cnt  <= '0;
                    done <= 1'b1;
                end else begin
                    cnt <= cnt + addressWidth'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_neuron_mac.sv
// tb/tb_neuron_mac.sv - randomized self-checking bench for neuron_mac against an arithmetic model
module tb_neuron_mac;

    localparam int NW = 10;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic signed [15:0] in_data;
    logic signed [15:0] bias;
    logic               ren;
    logic        [3:0]  radd;
    logic signed [15:0] wout;
    logic signed [15:0] out_data;
    logic               out_valid;

    logic [15:0] mem [NW];
    logic [15:0] frame_in [$];
    longint      exp_q [$];
    int          exp_idx = 0;
    int          checks = 0;
    int          errors = 0;
    int          pulses = 0;
    int          exp_pulses = 0;
    logic        prev_ov = 1'b0;

    neuron_mac dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .bias      (bias),
        .ren       (ren),
        .radd      (radd),
        .wout      (wout),
        .out_data  (out_data),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ren) wout <= mem[radd];
    end

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Real-valued neuron: sum(x*w) + b in fixed point, floor to integer scale, saturate, ReLU.
    function automatic longint model();
        longint s = 0;
        for (int i = 0; i < NW; i++)
            s += longint'($signed(frame_in[i])) * longint'($signed(mem[i]));
        s += longint'(bias) * 4096;
        s = s >>> 12;
        if (s > 32767) s = 32767;
        if (s < 0) s = 0;
        return s;
    endfunction

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            pulses++;
            if (exp_q.size() == 0) check("unexpected_out_valid", 1, 0);
            else check("out_data", out_data, exp_q.pop_front());
        end
        if (prev_ov && out_valid) check("pulse_width", 2, 1);
        prev_ov = out_valid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] d, input int gap);
        in_valid = 1'b1;
        in_data  = d;
        check("radd", radd, exp_idx);
        check("ren", ren, 1);
        tick();
        in_valid = 1'b0;
        frame_in.push_back(d);
        exp_idx = (exp_idx + 1) % NW;
        if (frame_in.size() == NW) begin
            exp_q.push_back(model());
            exp_pulses++;
            frame_in.delete();
        end
        repeat (gap) tick();
    endtask

    task automatic const_frame(input logic [15:0] w, input logic [15:0] x,
                               input logic [15:0] b, input logic [15:0] expv);
        for (int i = 0; i < NW; i++) mem[i] = w;
        bias = b;
        for (int i = 0; i < NW; i++) send(x, 0);
        tick();
        check("latency_early", out_valid, 0);
        tick();
        check("latency_pulse", out_valid, 1);
        check("const_data", out_data, expv);
        tick();
        check("pulse_end", out_valid, 0);
        check("hold_data", out_data, expv);
        repeat (2) tick();
    endtask

    task automatic rand_frame(input int max_gap);
        for (int i = 0; i < NW; i++) send(16'($urandom), $urandom_range(0, max_gap));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; bias = '0; wout = '0;
        for (int i = 0; i < NW; i++) mem[i] = '0;
        repeat (2) tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_radd", radd, 0);
        check("rst_ren", ren, 0);
        rst_n = 1'b1;
        tick();

        const_frame(16'h1000, 16'h0800, 16'h0000, 16'h5000);
        const_frame(16'hF000, 16'h1000, 16'h0000, 16'h0000);
        const_frame(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
        for (int i = 0; i < NW; i++) mem[i] = 16'($urandom);
        bias = 16'h1800;
        for (int i = 0; i < NW; i++) send(16'h0000, 0);
        repeat (3) tick();
        check("zero_input_bias", out_data, 16'h1800);

        // Back-to-back frames, the second with random gaps.
        for (int i = 0; i < NW; i++) mem[i] = 16'($urandom_range(0, 16'h1FFF)) - 16'h1000;
        bias = 16'($urandom_range(0, 16'h0FFF)) - 16'h0800;
        rand_frame(0);
        rand_frame(2);
        repeat (4) tick();

        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < NW; i++) mem[i] = 16'($urandom);
            bias = 16'($urandom);
            rand_frame(b);
            rand_frame(3);
            repeat (4) tick();
        end

        // Reset in the middle of a frame discards the partial frame.
        for (int i = 0; i < 4; i++) send(16'($urandom), 0);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_data", out_data, 0);
        check("midrst_radd", radd, 0);
        tick();
        rst_n = 1'b1;
        frame_in.delete();
        exp_idx = 0;
        tick();
        for (int i = 0; i < NW; i++) mem[i] = 16'($urandom_range(0, 16'h1FFF));
        bias = 16'h0400;
        for (int i = 0; i < NW; i++) send(16'($urandom_range(0, 16'h1FFF)), 0);
        repeat (5) tick();

        check("drain", exp_q.size(), 0);
        check("pulse_count", pulses, exp_pulses);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
